uart_fifo_wr_arb: RTL and testbench
===================================

# uart_fifo_wr_arb

Packet-atomic round-robin write arbiter that shares one UART TX FIFO (`uart_fifo_fwft` write port) between `NUM_REQ` byte sources such as the CPU register path, the loopback path and the auto-response generator. It grants one requester at a time and holds the grant until that requester's packet ends, so frames are never interleaved on the line. Writes are issued only against free-space credit, so the FIFO never overflows. A lock timeout releases a stalled owner.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `FIFO_DW`, default 8: data width.
- `USED_WIDTH`, default 3: width of the FIFO free-count input.
- `TIMEOUT_CYCLES`, default 1024: idle-lock cycles before forced release, at least 2.
- `i_clk`  in  1: clock.
- `i_rst`  in  1: reset. Synchronous, active-high.
- `i_req_valid`  in  NUM_REQ: per-requester beat valid.
- `i_req_data`  in  NUM_REQ×FIFO_DW: per-requester beat data, packed, requester i at `[i*FIFO_DW +: FIFO_DW]`.
- `i_req_last`  in  NUM_REQ: beat is the final byte of its packet.
- `o_req_ready`  out  NUM_REQ: per-requester beat accept.
- `i_fifo_free`  in  USED_WIDTH: FIFO free entries, reflects writes one cycle later.
- `o_fifo_wr`  out  1: FIFO write strobe, registered.
- `o_fifo_data`  out  FIFO_DW: FIFO write data, registered.
- `o_busy`  out  1: a requester holds the lock.
- `o_owner`  out  $clog2(NUM_REQ): current or last owner index.
- `o_timeout`  out  1: one-cycle pulse on forced release.

## Operation
- **States:**
  - `ARB_IDLE`: no lock is held.
  - `ARB_LOCKED`: a requester owns the FIFO write port.
- **In `ARB_IDLE`:**
  - If any `i_req_valid` is set, pick the first valid index at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Register the winner in `o_owner` and go to `ARB_LOCKED`.
  - No beat is accepted in `ARB_IDLE`; all `o_req_ready` bits are 0.
- **Credit rule:**
  - `credit_ok = i_fifo_free > o_fifo_wr`, zero-extended compare.
  - The subtraction accounts for the write that is in flight but not yet visible in `i_fifo_free`.
- **In `ARB_LOCKED`:**
  - `o_req_ready[o_owner] = credit_ok`. All other ready bits are 0. Ready is combinational.
  - **Accept:** `i_req_valid[o_owner] && o_req_ready[o_owner]`. On accept, next cycle `o_fifo_wr=1` and `o_fifo_data` equals the accepted byte. Otherwise `o_fifo_wr=0` and `o_fifo_data` holds its value.
  - **Accept with `i_req_last`:** go to `ARB_IDLE` and set `rr_ptr <= o_owner+1` (mod `NUM_REQ`).
  - **Timeout counter** (`$clog2(TIMEOUT_CYCLES+1)` bits):
    - Cleared on entry to `ARB_LOCKED` and on every accept.
    - Increments only when `!i_req_valid[o_owner]`.
    - Holds during credit stalls, so a full FIFO never causes a timeout.
  - **Timeout:** when the counter reaches `TIMEOUT_CYCLES-1` and the owner is still not valid, go to `ARB_IDLE`, pulse `o_timeout`, and set `rr_ptr <= o_owner+1`.
- **Boundaries:**
  - Non-owner valids are ignored while locked; their data may change freely.
  - Owner valid and timeout expiry in the same cycle: the beat is accepted and there is no timeout.
  - `i_fifo_free=0`: owner ready is 0 and there is no write.
  - `i_fifo_free=1` with `o_fifo_wr=1`: ready is 0, which prevents overflow.
  - Single-beat packet (last on the first beat): lock lasts exactly one accept cycle.
  - `rr_ptr` wraps from `NUM_REQ-1` to 0.
- **Reset:**
  - State `ARB_IDLE`, `rr_ptr=0`, `o_owner=0`, counter 0.
  - `o_fifo_wr=0`, `o_fifo_data=0`, `o_busy=0`, `o_timeout=0`.
  - All `o_req_ready` bits are 0 during reset.
  - Reset mid-packet drops the lock immediately. A write already registered in `o_fifo_wr` is cleared, and the partial packet is not completed.

## Timing
- Arbitration bubble: one cycle in `ARB_IDLE` per packet. The first accept is possible at cycle N+1 after valid appears at cycle N in idle.
- Throughput while locked with ample credit: one byte per cycle.
- Latency: accept at cycle t gives `o_fifo_wr` at t+1.
- `o_busy` is registered and equals `state==ARB_LOCKED`.
- `o_timeout` is registered and high for the single cycle after expiry, coincident with `ARB_IDLE`.
- Back-to-back packets from different requesters are separated by exactly one idle cycle.

## Structure
- `uart_pkg` gains the `uart_arb_state_t` enum (`ARB_IDLE`, `ARB_LOCKED`) and the `UART_ARB_TIMEOUT_DEF` constant.
- Sub-module `uart_rr_picker`: combinational priority rotate. Inputs are the request vector and `rr_ptr`; outputs are the winner index and an any-flag. It is reusable by the RX side.
- The top module contains the FSM, credit check, timeout counter and output registers.

## Test plan
- NUM_REQ=4, all idle, then req 2 sends 3 bytes 0x41, 0x42, 0x43 with last on 0x43 → owner=2, `o_fifo_wr` high for 3 consecutive cycles with those bytes, then `ARB_IDLE` and `rr_ptr=3`.
- Reqs 0 and 3 both valid at `rr_ptr=0`, each sending 2-byte packets → order is 0,0, then one idle cycle, then 3,3; FIFO bytes are never interleaved.
- Owner streaming with `i_fifo_free` falling 2→1→0 → at most 2 writes issued, ready drops while `free=1` and `o_fifo_wr=1`, and no write occurs at `free=0`.
- TIMEOUT_CYCLES=8, owner deasserts valid mid-packet → `o_timeout` pulses after 8 idle cycles and the lock passes to the next valid requester; a credit stall of 20 cycles yields no timeout.
- `i_rst` asserted at the cycle of an accept → next cycle `o_fifo_wr=0`, `o_busy=0`, `rr_ptr=0`.
- Single-beat packets from all 4 requesters, all continuously valid → grant order 0,1,2,3,0, each packet taking 2 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART TX path
package uart_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } uart_arb_state_t;

  localparam int UART_ARB_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/uart_rr_picker.sv
// rtl/uart_rr_picker.sv - combinational round-robin picker: first set request at or after ptr
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [IW-1:0]      o_win,
  output logic               o_any
);

  logic [IW-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    o_win = i_ptr;
    o_any = |i_req;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[idx]) begin
        o_win = idx;
      end
    end
  end

endmodule

// File: rtl/uart_fifo_wr_arb.sv
// rtl/uart_fifo_wr_arb.sv - packet-atomic round-robin arbiter for the UART TX FIFO write port
module uart_fifo_wr_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int FIFO_DW        = 8,
  parameter int USED_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = UART_ARB_TIMEOUT_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*FIFO_DW-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]           i_req_last,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic [USED_WIDTH-1:0]        i_fifo_free,
  output logic                         o_fifo_wr,
  output logic [FIFO_DW-1:0]           o_fifo_data,
  output logic                         o_busy,
  output logic [$clog2(NUM_REQ)-1:0]   o_owner,
  output logic                         o_timeout
);

  localparam int            IW       = $clog2(NUM_REQ);
  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES - 1);

  uart_arb_state_t    state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [FIFO_DW-1:0] data_q, data_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [IW-1:0]      next_ptr;
  logic               credit_ok;
  logic               own_valid;
  logic               own_last;
  logic [FIFO_DW-1:0] own_data;
  logic               accept;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .i_req (i_req_valid),
    .i_ptr (rr_ptr_q),
    .o_win (pick_idx),
    .o_any (pick_any)
  );

  // The registered write is not yet reflected in i_fifo_free, so reserve one entry for it.
  assign credit_ok = i_fifo_free > USED_WIDTH'(wr_q);
  assign own_valid = i_req_valid[owner_q];
  assign own_last  = i_req_last[owner_q];
  assign own_data  = i_req_data[int'(owner_q) * FIFO_DW +: FIFO_DW];
  assign accept    = (state_q == ARB_LOCKED) && own_valid && credit_ok && !i_rst;
  assign next_ptr  = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (accept) begin
          cnt_d = '0;
          if (own_last) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (!own_valid) begin
          // Only an absent owner ages the lock; credit stalls hold the count.
          if (cnt_q == CNT_MAX) begin
            cnt_d     = '0;
            state_d   = ARB_IDLE;
            rr_ptr_d  = next_ptr;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = '0;
    wr_d        = accept;
    data_d      = accept ? own_data : data_q;
    busy_d      = (state_d == ARB_LOCKED);
    if (!i_rst && state_q == ARB_LOCKED && credit_ok) begin
      o_req_ready[owner_q] = 1'b1;
    end
  end

  assign o_fifo_wr   = wr_q;
  assign o_fifo_data = data_q;
  assign o_busy      = busy_q;
  assign o_owner     = owner_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_fifo_wr_arb.sv
// tb/tb_uart_fifo_wr_arb.sv - self-checking bench for the UART TX FIFO write arbiter
module tb_uart_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int UW = 3;
  localparam int TO = 8;

  typedef struct {
    logic [UW-1:0] free;
    logic          vld;
    logic [DW-1:0] dat;
    logic          lst;
    logic [NR-1:0] exp_ready;
    logic          exp_wr;
  } credit_vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    valid, last, ready;
  logic [NR*DW-1:0] data;
  logic [UW-1:0]    free;
  logic             wr, busy, tmo;
  logic [DW-1:0]    wdata;
  logic [1:0]       owner;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  logic [8:0] src_b[NR][8];
  int         src_len[NR];
  int         src_idx[NR];
  int         log_req[$];
  int         log_cyc[$];

  credit_vec_t tbl[6];
  int exp_ord2[4];
  int exp_gap2[3];
  int exp_ord6[5];
  int tmo_seen;

  always #5 clk = ~clk;

  uart_fifo_wr_arb #(
    .NUM_REQ        (NR),
    .FIFO_DW        (DW),
    .USED_WIDTH     (UW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (valid),
    .i_req_data  (data),
    .i_req_last  (last),
    .o_req_ready (ready),
    .i_fifo_free (free),
    .o_fifo_wr   (wr),
    .o_fifo_data (wdata),
    .o_busy      (busy),
    .o_owner     (owner),
    .o_timeout   (tmo)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (wr === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_write_qsize", exp_q.size(), 1);
      else check("fifo_data", {24'd0, wdata}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = '0; last = '0; data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0;
      src_idx[i] = 0;
    end
    log_req.delete();
    log_cyc.delete();
  endtask

  task automatic add_beat(input int r, input logic [7:0] b, input logic l);
    src_b[r][src_len[r]] = {l, b};
    src_len[r]++;
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (src_idx[i] < src_len[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_src();
    for (int i = 0; i < NR; i++) begin
      if (src_idx[i] < src_len[i]) begin
        valid[i]          = 1'b1;
        data[i*DW +: DW]  = src_b[i][src_idx[i]][7:0];
        last[i]           = src_b[i][src_idx[i]][8];
      end else begin
        valid[i]          = 1'b0;
        data[i*DW +: DW]  = '0;
        last[i]           = 1'b0;
      end
    end
  endtask

  task automatic run_src(input int max_cyc);
    int cyc;
    logic [NR-1:0] hs;
    cyc = 0;
    while (pending() && cyc < max_cyc) begin
      drive_src();
      #1;
      hs = ready & valid;
      tick();
      cyc++;
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) begin
          log_req.push_back(i);
          log_cyc.push_back(cyc);
          src_idx[i]++;
        end
      end
    end
    drive_src();
    check("src_drain_in_budget", {31'd0, pending()}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{3'd2, 1'b1, 8'h61, 1'b0, 4'b0010, 1'b1};
    tbl[1] = '{3'd2, 1'b1, 8'h62, 1'b0, 4'b0010, 1'b1};
    tbl[2] = '{3'd1, 1'b1, 8'h63, 1'b0, 4'b0000, 1'b0};
    tbl[3] = '{3'd0, 1'b1, 8'h63, 1'b0, 4'b0000, 1'b0};
    tbl[4] = '{3'd0, 1'b1, 8'h63, 1'b0, 4'b0000, 1'b0};
    tbl[5] = '{3'd3, 1'b1, 8'h63, 1'b1, 4'b0010, 1'b1};
    exp_ord2 = '{0, 0, 3, 3};
    exp_gap2 = '{1, 2, 1};
    exp_ord6 = '{0, 1, 2, 3, 0};

    // Reset state
    rst = 1'b1; valid = '0; last = '0; data = '0; free = 3'd7;
    tick();
    check("rst_ready", {28'd0, ready}, 0);
    check("rst_wr", {31'd0, wr}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_timeout", {31'd0, tmo}, 0);
    check("rst_owner", {30'd0, owner}, 0);
    check("rst_data", {24'd0, wdata}, 0);
    tick();
    rst = 1'b0;

    // Requester 2 sends a three-byte packet
    tick(); tick();
    check("idle_busy", {31'd0, busy}, 0);
    valid = 4'b0100; data[23:16] = 8'h41; last = '0;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    #1;
    check("idle_no_ready", {28'd0, ready}, 0);
    tick();
    check("p1_owner", {30'd0, owner}, 2);
    check("p1_busy", {31'd0, busy}, 1);
    check("p1_ready", {28'd0, ready}, 32'h4);
    tick();
    data[23:16] = 8'h42;
    check("p1_wr0", {31'd0, wr}, 1);
    tick();
    data[23:16] = 8'h43; last[2] = 1'b1;
    check("p1_wr1", {31'd0, wr}, 1);
    tick();
    valid = '0; last = '0;
    check("p1_wr2", {31'd0, wr}, 1);
    check("p1_busy_end", {31'd0, busy}, 0);
    check("p1_rr_ptr", {30'd0, dut.rr_ptr_q}, 3);
    tick();
    check("p1_wr_off", {31'd0, wr}, 0);

    // Requesters 0 and 3 contend with two-byte packets
    do_reset();
    clear_src();
    add_beat(0, 8'hA0, 1'b0); add_beat(0, 8'hA1, 1'b1);
    add_beat(3, 8'hB0, 1'b0); add_beat(3, 8'hB1, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    exp_q.push_back(8'hB0); exp_q.push_back(8'hB1);
    run_src(40);
    tick(); tick();
    check("p2_accept_count", log_req.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < log_req.size()) check("p2_order", log_req[k], exp_ord2[k]);
    for (int k = 0; k < 3; k++)
      if (k + 1 < log_cyc.size()) check("p2_gap", log_cyc[k+1] - log_cyc[k], exp_gap2[k]);

    // Credit rule, table driven with requester 1 locked
    do_reset();
    free = 3'd7; valid = 4'b0010; data[15:8] = 8'h61; last = '0;
    tick();
    check("cr_owner", {30'd0, owner}, 1);
    for (int r = 0; r < 6; r++) begin
      free = tbl[r].free; valid[1] = tbl[r].vld; data[15:8] = tbl[r].dat; last[1] = tbl[r].lst;
      #1;
      check("cr_ready", {28'd0, ready}, {28'd0, tbl[r].exp_ready});
      if (tbl[r].exp_wr) exp_q.push_back(tbl[r].dat);
      tick();
      check("cr_wr", {31'd0, wr}, {31'd0, tbl[r].exp_wr});
    end
    valid = '0; last = '0; free = 3'd7;
    tick();
    check("cr_idle", {31'd0, busy}, 0);

    // Lock timeout after owner goes quiet, lock passes to requester 2
    do_reset();
    valid = 4'b0001; data[7:0] = 8'h70; last = '0;
    exp_q.push_back(8'h70);
    tick();
    check("to_owner0", {30'd0, owner}, 0);
    tick();
    valid = 4'b0100; data[23:16] = 8'h71; last[2] = 1'b1; data[7:0] = 8'h5A;
    exp_q.push_back(8'h71);
    for (int k = 1; k <= TO; k++) begin
      tick();
      data[7:0] = 8'($urandom);
      check("to_pulse", {31'd0, tmo}, (k == TO) ? 1 : 0);
      check("to_busy", {31'd0, busy}, (k == TO) ? 0 : 1);
    end
    tick();
    check("to_pulse_single", {31'd0, tmo}, 0);
    check("to_next_owner", {30'd0, owner}, 2);
    check("to_next_busy", {31'd0, busy}, 1);
    tick();
    valid = '0; last = '0;
    tick(); tick();

    // Long credit stall never times out
    do_reset();
    free = 3'd0; valid = 4'b0010; data[15:8] = 8'h80; last = 4'b0010;
    tick();
    tmo_seen = 0;
    repeat (20) begin
      tick();
      if (tmo) tmo_seen++;
    end
    check("stall_no_timeout", tmo_seen, 0);
    check("stall_busy", {31'd0, busy}, 1);
    free = 3'd7;
    exp_q.push_back(8'h80);
    tick();
    check("stall_wr", {31'd0, wr}, 1);
    valid = '0; last = '0;
    tick();

    // Reset on an accept cycle drops the lock and the pending write
    do_reset();
    valid = 4'b1000; data[31:24] = 8'h90; last = '0;
    exp_q.push_back(8'h90);
    tick();
    check("rs_owner", {30'd0, owner}, 3);
    tick();
    data[31:24] = 8'h91; rst = 1'b1;
    #1;
    check("rs_ready", {28'd0, ready}, 0);
    tick();
    check("rs_wr", {31'd0, wr}, 0);
    check("rs_busy", {31'd0, busy}, 0);
    check("rs_owner0", {30'd0, owner}, 0);
    check("rs_rr_ptr", {30'd0, dut.rr_ptr_q}, 0);
    rst = 1'b0; valid = '0;
    tick();

    // Single-beat packets from every requester, continuously valid
    do_reset();
    clear_src();
    add_beat(0, 8'h10, 1'b1); add_beat(1, 8'h11, 1'b1); add_beat(2, 8'h12, 1'b1);
    add_beat(3, 8'h13, 1'b1); add_beat(0, 8'h20, 1'b1);
    exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
    exp_q.push_back(8'h13); exp_q.push_back(8'h20);
    run_src(60);
    tick(); tick();
    check("sb_accept_count", log_req.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < log_req.size()) check("sb_order", log_req[k], exp_ord6[k]);
    for (int k = 0; k < 4; k++)
      if (k + 1 < log_cyc.size()) check("sb_gap", log_cyc[k+1] - log_cyc[k], 2);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
